// File: rtl/alarm_sched.sv
// ---------------------------------------------------------------------------
// alarm_sched
//
// Round-robin scheduler that shares one load port among N requesters and
// runs N one-shot down-count alarms on a common time base.
//
// Each cycle, the first eligible requester at or after the rotating pointer
// is granted. It is searched upward from the pointer and wraps from N-1 to 0.
// On the grant edge its length is sampled into the channel counter.
// Armed channels count down on `tick` and pulse `fire` for one cycle on
// expiry. A channel's `cancel` drops its armed alarm and masks its request.
// On one channel in one edge, the priority order is cancel, then load, then
// tick.
//
// Ports:
//   clock   in   1     system clock, rising edge
//   reset   in   1     asynchronous, active-high reset
//   tick    in   1     time-base enable, one clock wide per time unit
//   req     in   N     per-channel load request, held until granted
//   value   in   N*W   packed alarm lengths, channel i at [i*W +: W]
//   cancel  in   N     per-channel abort of a running or requested alarm
//   grant   out  N     one-hot load acknowledge (combinational)
//   busy    out  N     channel armed and counting
//   fire    out  N     registered one-cycle expiry pulse
// ---------------------------------------------------------------------------
module alarm_sched #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           tick,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] value,
    input  logic [N-1:0]   cancel,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   busy,
    output logic [N-1:0]   fire
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    typedef logic [PW-1:0] idx_t;

    idx_t         ptr;       // highest-priority channel this cycle
    idx_t         gidx;      // index of the granted channel
    idx_t         cand;      // search cursor
    logic         found;
    logic [N-1:0] eligible;
    logic [W-1:0] cnt [N];   // remaining ticks per channel

    // Step to the next channel. The step wraps at N-1, so a non-power-of-two
    // N works too.
    function automatic idx_t wrap_inc(input idx_t i);
        return (i == idx_t'(N - 1)) ? '0 : idx_t'(i + 1'b1);
    endfunction

    // Reset masks the eligible set so that grant is low while reset is held.
    assign eligible = req & ~cancel & ~{N{reset}};

    // Rotating priority search. It starts at ptr and takes the first
    // eligible channel.
    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path leaves one unassigned (no latches).
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && eligible[cand]) begin
                grant[cand] = 1'b1;
                gidx        = cand;
                found       = 1'b1;
            end
            cand = wrap_inc(cand);
        end
    end

    // Pointer and alarm bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr  <= '0;
            busy <= '0;
            fire <= '0;
            // NOTE: the counter bank is only N registers. Clearing it keeps the state after reset fully defined.
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // NOTE: state is updated with non-blocking assignments, so every channel sees the pre-edge values.
            if (found) begin
                ptr <= wrap_inc(gidx);
            end
            for (int i = 0; i < N; i++) begin
                // fire is a pulse. It drops on any edge that does not set it.
                fire[i] <= 1'b0;
                if (cancel[i]) begin
                    // Cancel wins. The alarm is dropped and no fire is produced.
                    busy[i] <= 1'b0;
                end else if (grant[i]) begin
                    // A load re-arms the channel. A zero length expires at once.
                    // A tick on this same edge is ignored.
                    cnt[i]  <= value[i*W +: W];
                    busy[i] <= (value[i*W +: W] != '0);
                    fire[i] <= (value[i*W +: W] == '0);
                end else if (tick && busy[i]) begin
                    if (cnt[i] == W'(1)) begin
                        cnt[i]  <= '0;
                        busy[i] <= 1'b0;
                        fire[i] <= 1'b1;
                    end else if (cnt[i] > W'(1)) begin
                        cnt[i] <= cnt[i] - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/alarm_sched.md
Name: alarm_sched

Overview:
- Round-robin scheduler that shares one load port among N requesters and runs N one-shot down-count alarms on a common time base.
- Each requester asks for an alarm of a given length. The block grants one load per clock, counts on `tick`, and pulses a per-channel `fire` on expiry.
- Sits between software/peripheral requesters and the timer datapath. It replaces N independently wired alarm instances with one arbitrated, cancellable bank.

Parameters:
- N, 4, number of channels (requesters), ≥2
- W, 8, alarm count width in bits

Ports:
- clock, in, 1, system clock; all state changes on rising edge
- reset, in, 1, asynchronous, active-high reset
- tick, in, 1, time-base enable; one clock-wide pulse per time unit
- req, in, N, per-channel load request; held high until granted
- value, in, N*W, packed alarm lengths; channel i at bits [i*W +: W]
- cancel, in, N, per-channel abort of a running or requested alarm
- grant, out, N, one-hot load acknowledge (combinational, same cycle as accepted req)
- busy, out, N, channel alarm armed and counting
- fire, out, N, registered one-cycle expiry pulse

Behaviour:
- Reset (async, active-high) clears the following, and all outputs go low while reset is high:
  - all counters to 0
  - busy to 0
  - fire to 0
  - round-robin pointer to 0 (channel 0 highest priority)
  - grant to 0
- Arbitration:
  - Eligible set = req & ~cancel & ~{N{reset}}.
  - grant = one-hot of the first eligible channel, searching upward from the pointer and wrapping at N-1 → 0.
  - grant is 0 if the eligible set is empty.
  - At most one grant per cycle.
- Pointer update: on a clock edge with grant nonzero, pointer ← (granted index + 1) mod N. It is unchanged otherwise.
- Handshake:
  - value[i] is sampled on the edge where grant[i]=1.
  - The requester drops req[i] after that edge.
  - A req held high after its grant is treated as a new request.
  - Ungranted req must stay stable, including value.
- Load on grant of channel i with length V:
  - V≠0: cnt[i] ← V, busy[i] ← 1. Any previous running alarm on i is replaced (re-arm), with no fire for the old one.
  - V=0: busy[i] ← 0, fire[i] ← 1 on that edge, i.e. fire is visible the cycle after grant.
- Counting on an edge with tick=1, for each channel with busy=1 not being loaded or cancelled that edge:
  - cnt>1: cnt ← cnt−1.
  - cnt==1: cnt ← 0, busy ← 0, fire ← 1.
- Alarm length V therefore expires on the V-th tick edge after the load edge. A tick coincident with the load edge does not count.
- fire is a pulse: cleared on every edge that does not set it. Back-to-back fire on the same channel is possible (expiry, then an immediate V=0 reload).
- Cancel:
  - cancel[i] on an edge forces busy[i] ← 0 and suppresses any fire[i] that would be set on that edge.
  - cancel[i] masks req[i] from arbitration in the same cycle.
  - cancel on an idle channel is a no-op.
- Simultaneous events, same channel same edge, priority: cancel > load > tick.
- Different channels are independent. Loads, ticks and fires on other channels proceed in parallel.
- Arithmetic: counters are W-bit unsigned and never wrap. Decrement happens only when cnt≥1 and busy=1.
- Reset mid-operation: all armed alarms are dropped silently with no fire. After reset deassert, arbitration restarts at channel 0.

Test Plan:
1. **Single alarm.** Reset; req=0001, value[0]=8'h03; tick every 4 clocks → grant=0001 for 1 cycle, busy[0]=1; fire[0] is a 1-cycle pulse after the 3rd tick edge following load; busy[0]=0 on the same edge.
2. **Round-robin.** req=1111 held, each dropped on its grant → grants 0001, 0010, 0100, 1000 on consecutive cycles. Then req=1001 → next grant=0001 (pointer wrapped to 0).
3. **Zero length.** req[2] with value 8'h00 → grant=0100; fire[2] pulses the next cycle; busy[2] stays 0; no tick required.
4. **Cancel and re-arm.**
   - ch1 loaded with 8'h05; after 2 ticks, assert cancel[1] → busy[1]=0, no fire[1] ever.
   - Reload ch1 with 8'h02 after 1 tick → fire[1] after 2 further ticks (not the original count).
5. **Coincident events.**
   - tick on the grant edge of ch3 (value 8'h01) → not counted; fire[3] on the next tick edge.
   - cancel[0] and req[0] in the same cycle → grant[0]=0, busy[0]=0.
6. **Async reset mid-count.** Channels 0 and 1 busy with 8'h11 and 8'h07; assert reset between clock edges → busy, fire, grant go 0 immediately. After release, req=0010 and req=0001 together → grant=0001 first.
